// File: rtl/sevenseg_scan_driver.sv
// Purpose: time-multiplexed 7-segment scan driver, double-buffered display data, blanking gap between digits.
// Latency: all outputs registered; a digit whose frame begins on a load's apply edge already shows the new pattern.
// Backpressure: none; load is always accepted, last load before a frame boundary wins.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   seg_in, digit_en  per-digit active-low patterns (digit k = seg_in[8k+7:8k]) and enables
//   load              one-cycle strobe capturing seg_in/digit_en into the pending buffer
//   pending           pending buffer holds data not yet applied
//   an, seg           active-low anode drives (at most one low) and shared segment bus
//   frame_done        one-cycle pulse after the last digit's ON period
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int TICKS_ON    = 12500,
    parameter int TICKS_BLANK = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    pending,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int TICK_MAX = (TICKS_ON > TICKS_BLANK) ? TICKS_ON : TICKS_BLANK;
    localparam int CW       = $clog2(TICK_MAX + 1);
    localparam int IW       = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] ON_LAST    = CW'(TICKS_ON - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(TICKS_BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                     state;
    logic [CW-1:0]              tick;
    logic [IW-1:0]              idx;
    logic [NUM_DIGITS-1:0][7:0] shadow_seg;
    logic [NUM_DIGITS-1:0]      shadow_en;
    logic [NUM_DIGITS-1:0][7:0] pend_seg;
    logic [NUM_DIGITS-1:0]      pend_en;

    logic                       blank_end;
    logic                       apply;
    logic [NUM_DIGITS-1:0][7:0] next_seg;
    logic [NUM_DIGITS-1:0]      next_en;

    assign blank_end = (state == ST_BLANK) && (tick == BLANK_LAST);
    // Frame boundary: leaving the gap in front of digit 0 with data waiting.
    assign apply     = blank_end && (idx == '0) && pending;
    // The registered outputs for the first digit of a frame must already see
    // the data being applied on this same edge, so bypass the shadow copy.
    assign next_seg  = apply ? pend_seg : shadow_seg;
    assign next_en   = apply ? pend_en  : shadow_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            tick       <= '0;
            idx        <= '0;
            shadow_seg <= '1;
            shadow_en  <= '0;
            pend_seg   <= '0;
            pend_en    <= '0;
            pending    <= 1'b0;
            an         <= '1;
            seg        <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A load on the apply edge wins the pending buffer: the apply
            // consumes the old contents and the new data waits a frame.
            if (load) begin
                pend_seg <= seg_in;
                pend_en  <= digit_en;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end

            if (apply) begin
                shadow_seg <= pend_seg;
                shadow_en  <= pend_en;
            end

            case (state)
                ST_BLANK: begin
                    if (blank_end) begin
                        state <= ST_ON;
                        tick  <= '0;
                        // Disabled digits keep their slot but stay dark.
                        if (next_en[idx]) begin
                            an  <= ~(NUM_DIGITS'(1) << idx);
                            seg <= next_seg[idx];
                        end else begin
                            an  <= '1;
                            seg <= 8'hFF;
                        end
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                ST_ON: begin
                    if (tick == ON_LAST) begin
                        state <= ST_BLANK;
                        tick  <= '0;
                        an    <= '1;
                        seg   <= 8'hFF;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

endmodule
